// File: rtl/spi_scheduler_if.sv
// Bundle of requester-side and spi_master-side signals around spi_scheduler.
// slave: scheduler view; master: requesters and spi_master (testbench) view.
interface spi_scheduler_if;
   logic [3:0]  req;
   logic [11:0] req_ss;
   logic [63:0] req_len;
   logic [31:0] req_data;
   logic [3:0]  grant;
   logic [3:0]  tx_next;
   logic [3:0]  rx_valid;
   logic [7:0]  rx_data;
   logic [3:0]  done;
   logic [2:0]  m_ss;
   logic [7:0]  m_data_in;
   logic [15:0] m_how_many_bytes;
   logic        m_trigger;
   logic        m_busy;
   logic        m_new_data;
   logic [7:0]  m_data_out;

   modport slave (
      input  req, req_ss, req_len, req_data, m_busy, m_new_data, m_data_out,
      output grant, tx_next, rx_valid, rx_data, done,
             m_ss, m_data_in, m_how_many_bytes, m_trigger
   );

   modport master (
      output req, req_ss, req_len, req_data, m_busy, m_new_data, m_data_out,
      input  grant, tx_next, rx_valid, rx_data, done,
             m_ss, m_data_in, m_how_many_bytes, m_trigger
   );
endinterface

// File: rtl/spi_scheduler.sv
// Round-robin scheduler sharing one spi_master among four requesters.
// Define SPI_SCHED_PRIORITY_EN to give requester 0 absolute priority.
module spi_scheduler #(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic           sysclk,
   input  logic           rst,
   spi_scheduler_if.slave bus
);

   localparam int unsigned PTR_W       = $clog2(NREQ);
   localparam int unsigned TIMER_W     = 8;
   localparam logic [TIMER_W-1:0] GAP_LAST =
      (GAP_CYCLES == 0) ? TIMER_W'(0) : TIMER_W'(GAP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] BUSY_TIMEOUT_LAST = TIMER_W'(7);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      XFER,
      GAP
   } state_e;

   state_e               state_q, state_d;
   logic [3:0]           grant_q, grant_d;
   logic [3:0]           tx_next_q, tx_next_d;
   logic [3:0]           rx_valid_q, rx_valid_d;
   logic [3:0]           done_q, done_d;
   logic                 m_trigger_q, m_trigger_d;
   logic [2:0]           m_ss_q, m_ss_d;
   logic [15:0]          m_len_q, m_len_d;
   logic [7:0]           rx_data_q, rx_data_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;

   logic [PTR_W-1:0]     win;
   logic                 win_found;
   logic [2:0]           win_ss;
   logic [15:0]          win_len;
   logic [7:0]           m_data_in_c;

   // Winner: first requesting index at or after the round-robin pointer.
   always_comb begin
      win       = rr_ptr_q;
      win_found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (!win_found && bus.req[rr_ptr_q + PTR_W'(k)]) begin
            win       = rr_ptr_q + PTR_W'(k);
            win_found = 1'b1;
         end
      end
`ifdef SPI_SCHED_PRIORITY_EN
      if (bus.req[0]) begin
         win = PTR_W'(0);
      end
`else
`endif
      case (win)
         2'd0:    begin win_ss = bus.req_ss[2:0];  win_len = bus.req_len[15:0];  end
         2'd1:    begin win_ss = bus.req_ss[5:3];  win_len = bus.req_len[31:16]; end
         2'd2:    begin win_ss = bus.req_ss[8:6];  win_len = bus.req_len[47:32]; end
         default: begin win_ss = bus.req_ss[11:9]; win_len = bus.req_len[63:48]; end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      tx_next_d   = '0;
      rx_valid_d  = '0;
      done_d      = '0;
      m_trigger_d = 1'b0;
      m_ss_d      = m_ss_q;
      m_len_d     = m_len_q;
      rx_data_d   = rx_data_q;
      rr_ptr_d    = rr_ptr_q;
      cnt_d       = cnt_q;
      timer_d     = timer_q;

      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               grant_d  = 4'(1) << win;
               m_ss_d   = win_ss;
               m_len_d  = win_len;
               cnt_d    = win_len;
               rr_ptr_d = win + PTR_W'(1);
               state_d  = LAUNCH;
            end
         end
         LAUNCH: begin
            timer_d = '0;
            // Zero-length requests complete without touching the spi_master.
            if (m_len_q == 16'd0) begin
               done_d  = grant_q;
               grant_d = '0;
               state_d = GAP;
            end else begin
               m_trigger_d = 1'b1;
               state_d     = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (bus.m_busy) begin
               state_d = XFER;
            end else if (timer_q == BUSY_TIMEOUT_LAST) begin
               done_d  = grant_q;
               grant_d = '0;
               timer_d = '0;
               state_d = GAP;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         XFER: begin
            if (bus.m_new_data) begin
               rx_valid_d = grant_q;
               tx_next_d  = grant_q;
               rx_data_d  = bus.m_data_out;
               if (cnt_q != 16'd0) begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
            if (!bus.m_busy) begin
               done_d  = grant_q;
               grant_d = '0;
               timer_d = '0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (timer_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         tx_next_q   <= '0;
         rx_valid_q  <= '0;
         done_q      <= '0;
         m_trigger_q <= 1'b0;
         m_ss_q      <= '0;
         m_len_q     <= '0;
         rx_data_q   <= '0;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         tx_next_q   <= tx_next_d;
         rx_valid_q  <= rx_valid_d;
         done_q      <= done_d;
         m_trigger_q <= m_trigger_d;
         m_ss_q      <= m_ss_d;
         m_len_q     <= m_len_d;
         rx_data_q   <= rx_data_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
         timer_q     <= timer_d;
      end
   end

   // TX byte follows the current owner combinationally.
   always_comb begin
      m_data_in_c = ({8{grant_q[0]}} & bus.req_data[7:0])
                  | ({8{grant_q[1]}} & bus.req_data[15:8])
                  | ({8{grant_q[2]}} & bus.req_data[23:16])
                  | ({8{grant_q[3]}} & bus.req_data[31:24]);
   end

   assign bus.grant            = grant_q;
   assign bus.tx_next          = tx_next_q;
   assign bus.rx_valid         = rx_valid_q;
   assign bus.rx_data          = rx_data_q;
   assign bus.done             = done_q;
   assign bus.m_ss             = m_ss_q;
   assign bus.m_how_many_bytes = m_len_q;
   assign bus.m_trigger        = m_trigger_q;
   assign bus.m_data_in        = m_data_in_c;

endmodule

// File: tb/tb_spi_scheduler.sv
// Self-checking bench for spi_scheduler: directed corner cases then random traffic
// against a round-robin reference model and a behavioural spi_master.
module tb_spi_scheduler;

   localparam int GAP = 2;

   logic sysclk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   rr_start = 0;

   spi_scheduler_if bus ();

   spi_scheduler #(.NREQ(4), .GAP_CYCLES(GAP)) dut (
      .sysclk (sysclk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 sysclk = ~sysclk;

   task automatic tick;
      @(posedge sysclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference arbiter: first requester at or after the start index, wrapping mod 4.
   function automatic int exp_winner(input logic [3:0] r);
      for (int k = 0; k < 4; k++) begin
         int i = (rr_start + k) % 4;
         if (r[i]) return i;
      end
      return 0;
   endfunction

   // One complete transaction; returns at the sample where done is visible.
   task automatic txn(input bit chk_gap, input int extra, input bit no_busy, input bit drop);
      int         w;
      int         len;
      int         cyc;
      logic [3:0] oh;
      logic [7:0] b;
      w   = exp_winner(bus.req);
      oh  = 4'(1) << w;
      len = int'(bus.req_len[16*w +: 16]);
      cyc = 0;
      while (bus.grant == 4'd0 && cyc < 40) begin
         tick;
         cyc++;
      end
      if (chk_gap) check("gap_to_grant", 64'(cyc), 64'(GAP + 1));
      check("grant", 64'(bus.grant), 64'(oh));
      check("m_ss", 64'(bus.m_ss), 64'(bus.req_ss[3*w +: 3]));
      check("m_how_many_bytes", 64'(bus.m_how_many_bytes), 64'(len));
      check("m_data_in", 64'(bus.m_data_in), 64'(bus.req_data[8*w +: 8]));
      rr_start = (w + 1) % 4;
      if (drop) bus.req = 4'd0;
      tick;
      if (len == 0) begin
         check("len0_trigger", 64'(bus.m_trigger), 64'(0));
         check("len0_done", 64'(bus.done), 64'(oh));
         check("len0_grant", 64'(bus.grant), 64'(0));
         return;
      end
      check("trigger", 64'(bus.m_trigger), 64'(1));
      if (no_busy) begin
         cyc = 0;
         while (bus.done == 4'd0 && cyc < 20) begin
            tick;
            cyc++;
         end
         check("timeout_cycles", 64'(cyc), 64'(8));
         check("timeout_done", 64'(bus.done), 64'(oh));
         check("timeout_grant", 64'(bus.grant), 64'(0));
         return;
      end
      bus.m_busy = 1'b1;
      tick;
      check("trigger_one_cycle", 64'(bus.m_trigger), 64'(0));
      for (int k = 0; k < len + extra; k++) begin
         b              = 8'($urandom);
         bus.m_data_out = b;
         bus.m_new_data = 1'b1;
         tick;
         bus.m_new_data = 1'b0;
         check("rx_valid", 64'(bus.rx_valid), 64'(oh));
         check("tx_next", 64'(bus.tx_next), 64'(oh));
         check("rx_data", 64'(bus.rx_data), 64'(b));
      end
      bus.m_busy = 1'b0;
      tick;
      check("done", 64'(bus.done), 64'(oh));
      check("grant_clear", 64'(bus.grant), 64'(0));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_grant"}, 64'(bus.grant), 64'(0));
      check({tag, "_done"}, 64'(bus.done), 64'(0));
      check({tag, "_rx_valid"}, 64'(bus.rx_valid), 64'(0));
      check({tag, "_tx_next"}, 64'(bus.tx_next), 64'(0));
      check({tag, "_trigger"}, 64'(bus.m_trigger), 64'(0));
      check({tag, "_m_ss"}, 64'(bus.m_ss), 64'(0));
      check({tag, "_m_len"}, 64'(bus.m_how_many_bytes), 64'(0));
      check({tag, "_rx_data"}, 64'(bus.rx_data), 64'(0));
      check({tag, "_m_data_in"}, 64'(bus.m_data_in), 64'(0));
   endtask

   initial begin
      int cyc;
      rst            = 1'b1;
      bus.req        = 4'd0;
      bus.req_ss     = 12'h000;
      bus.req_len    = 64'd0;
      bus.req_data   = 32'hA1B2C3D4;
      bus.m_busy     = 1'b0;
      bus.m_new_data = 1'b0;
      bus.m_data_out = 8'h00;
      tick;
      tick;
      check_reset_values("reset");
      rst = 1'b0;

      // Stray new_data while idle must not reach any requester.
      bus.m_new_data = 1'b1;
      bus.m_data_out = 8'hEE;
      tick;
      bus.m_new_data = 1'b0;
      check("idle_new_data_rx_valid", 64'(bus.rx_valid), 64'(0));
      check("idle_new_data_rx_data", 64'(bus.rx_data), 64'(0));

      // Single requester 1, ss=3, three bytes.
      bus.req             = 4'b0010;
      bus.req_ss[5:3]     = 3'd3;
      bus.req_len[31:16]  = 16'd3;
      txn(1'b0, 0, 1'b0, 1'b0);

      // Zero-length request from requester 2.
      bus.req             = 4'b0100;
      bus.req_len[47:32]  = 16'd0;
      txn(1'b1, 0, 1'b0, 1'b0);

      // Reset during a transfer after the first of three bytes.
      bus.req             = 4'b0100;
      bus.req_ss[8:6]     = 3'd5;
      bus.req_len[47:32]  = 16'd3;
      cyc = 0;
      while (bus.grant == 4'd0 && cyc < 40) begin
         tick;
         cyc++;
      end
      check("abort_grant", 64'(bus.grant), 64'(4'b0100));
      tick;
      check("abort_trigger", 64'(bus.m_trigger), 64'(1));
      bus.m_busy = 1'b1;
      tick;
      bus.m_data_out = 8'h5A;
      bus.m_new_data = 1'b1;
      tick;
      bus.m_new_data = 1'b0;
      check("abort_rx_data", 64'(bus.rx_data), 64'(8'h5A));
      rst     = 1'b1;
      bus.req = 4'd0;
      tick;
      rst        = 1'b0;
      bus.m_busy = 1'b0;
      check_reset_values("abort");
      tick;
      check("abort_no_done", 64'(bus.done), 64'(0));
      rr_start = 0;

      // All four requesting, one byte each: full rotation starting at 0.
      bus.req     = 4'b1111;
      bus.req_len = {16'd1, 16'd1, 16'd1, 16'd1};
      bus.req_ss  = {3'd4, 3'd3, 3'd2, 3'd1};
      txn(1'b0, 0, 1'b0, 1'b0);
      for (int t = 0; t < 4; t++) txn(1'b1, 0, 1'b0, 1'b0);

      // spi_master never reports busy.
      bus.req            = 4'b1000;
      bus.req_len[63:48] = 16'd2;
      txn(1'b1, 0, 1'b1, 1'b0);

      // Random traffic, including dropped requests and surplus new_data pulses.
      for (int t = 0; t < 30; t++) begin
         bus.req      = 4'($urandom_range(1, 15));
         bus.req_ss   = 12'($urandom);
         bus.req_data = $urandom;
         for (int i = 0; i < 4; i++) bus.req_len[16*i +: 16] = 16'($urandom_range(0, 3));
         txn(1'b1, int'($urandom_range(0, 1)), (t % 9) == 4, $urandom_range(0, 1) == 1);
      end

      bus.req = 4'd0;
      tick;
      tick;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
